// File: rtl/pulp_cg_pkg.sv
// Shared types and widths for the multi-channel clock-gate controller.
package pulp_cg_pkg;
  localparam int CG_STATE_W = 2;
  localparam int WAKE_CNT_W = 4;

  typedef enum logic [CG_STATE_W-1:0] {
    OFF   = 2'd0,
    WAKE  = 2'd1,
    ON    = 2'd2,
    DRAIN = 2'd3
  } cg_state_e;
endpackage

// File: rtl/pulp_cg_channel.sv
// One gated channel: wake/settle, idle auto-gating and drain before the enable drops.
module pulp_cg_channel
  import pulp_cg_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned WAKE_CYCLES  = 2,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic        RESET_ON     = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             busy_i,
  input  logic [CNT_W-1:0] idle_thresh_i,
  output logic             ack_o,
  output logic             en_o,
  output cg_state_e        state_o
);
  localparam logic [WAKE_CNT_W-1:0] WAKE_INIT  = WAKE_CNT_W'(WAKE_CYCLES - 1);
  localparam logic [WAKE_CNT_W-1:0] DRAIN_INIT = WAKE_CNT_W'(DRAIN_CYCLES);

  cg_state_e             state_q, state_d;
  logic                  ack_q, ack_d, en_q, en_d;
  logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d, drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]      idle_cnt_q, idle_cnt_d;
  logic                  active, idle_hit;

  assign active   = req_i | busy_i;
  // Extra bit keeps idle_cnt+1 from wrapping when the counter is saturated.
  assign idle_hit = (idle_thresh_i != '0) &&
                    (({1'b0, idle_cnt_q} + 1'b1) >= {1'b0, idle_thresh_i});

  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    en_d        = en_q;
    wake_cnt_d  = wake_cnt_q;
    drain_cnt_d = drain_cnt_q;
    idle_cnt_d  = '0;
    unique case (state_q)
      OFF: begin
        ack_d = 1'b0;
        en_d  = 1'b0;
        if (req_i) begin
          state_d    = WAKE;
          wake_cnt_d = WAKE_INIT;
          en_d       = 1'b1;
        end
      end
      WAKE: begin
        en_d = 1'b1;
        if (wake_cnt_q == '0) begin
          state_d = ON;
          ack_d   = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q - 1'b1;
        end
      end
      ON: begin
        en_d  = 1'b1;
        ack_d = 1'b1;
        if (!active) idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;
        if (!active && idle_hit) begin
          state_d     = DRAIN;
          ack_d       = 1'b0;
          drain_cnt_d = DRAIN_INIT;
        end
      end
      DRAIN: begin
        en_d = 1'b1;
        if (active) begin
          state_d = ON;
          ack_d   = 1'b1;
        end else if (drain_cnt_q == '0) begin
          state_d = OFF;
          en_d    = 1'b0;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RESET_ON ? ON : OFF;
      ack_q       <= RESET_ON;
      en_q        <= RESET_ON;
      wake_cnt_q  <= '0;
      drain_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      en_q        <= en_d;
      wake_cnt_q  <= wake_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign ack_o   = ack_q;
  assign en_o    = en_q;
  assign state_o = state_q;
endmodule

// File: rtl/pulp_clock_gating_ctrl.sv
// Multi-channel clock-gate enable controller; CG_STATS_EN adds per-channel gated-cycle counters.
module pulp_clock_gating_ctrl
  import pulp_cg_pkg::*;
#(
  parameter int unsigned     N_CH         = 4,
  parameter int unsigned     CNT_W        = 8,
  parameter int unsigned     WAKE_CYCLES  = 2,
  parameter int unsigned     DRAIN_CYCLES = 2,
  parameter logic [N_CH-1:0] RESET_ON     = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   test_en_i,
  input  logic [N_CH-1:0]        req_i,
  input  logic [N_CH-1:0]        busy_i,
  input  logic [N_CH-1:0]        force_on_i,
  input  logic [CNT_W-1:0]       idle_thresh_i,
`ifdef CG_STATS_EN
  input  logic                   stats_clr_i,
  output logic [N_CH-1:0][31:0]  gated_cnt_o,
`endif
  output logic [N_CH-1:0]        ack_o,
  output logic [N_CH-1:0]        clk_en_o,
  output logic [2*N_CH-1:0]      state_o
);
  logic [N_CH-1:0] en_q_vec;

  // Overrides only touch the enable path; FSM state and ack stay untouched.
  assign clk_en_o = en_q_vec | force_on_i | {N_CH{test_en_i}};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    cg_state_e ch_state;

    pulp_cg_channel #(
      .CNT_W        (CNT_W),
      .WAKE_CYCLES  (WAKE_CYCLES),
      .DRAIN_CYCLES (DRAIN_CYCLES),
      .RESET_ON     (RESET_ON[g])
    ) u_ch (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_i         (req_i[g]),
      .busy_i        (busy_i[g]),
      .idle_thresh_i (idle_thresh_i),
      .ack_o         (ack_o[g]),
      .en_o          (en_q_vec[g]),
      .state_o       (ch_state)
    );

    assign state_o[CG_STATE_W*g +: CG_STATE_W] = ch_state;

`ifdef CG_STATS_EN
    logic [31:0] gcnt_q, gcnt_d;

    always_comb begin
      gcnt_d = gcnt_q;
      if (stats_clr_i)                        gcnt_d = '0;
      else if (!clk_en_o[g] && gcnt_q != '1) gcnt_d = gcnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) gcnt_q <= '0;
      else       gcnt_q <= gcnt_d;
    end

    assign gated_cnt_o[g] = gcnt_q;
`endif
  end
endmodule
